// File: rtl/morse_decoder.sv
// Morse receiver for letters A-H: times marks/spaces in units of TICK_DIV
// clocks and decodes the symbol string to a 3-bit letter code.
module morse_decoder #(
  parameter int TICK_DIV  = 25000000,
  parameter int DASH_MIN  = 2,
  parameter int GAP_UNITS = 3,
  parameter int LONG_MAX  = 6
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy,
  output logic [2:0] sym_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PC_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0] U_DASH = 3'(DASH_MIN);
  localparam logic [2:0] U_GAP  = 3'(GAP_UNITS);
  localparam logic [2:0] U_LONG = 3'(LONG_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    DECODE,
    ERROR
  } state_t;

  state_t        r_state;
  logic          r_ks1;
  logic          r_ks2;
  logic [PW-1:0] r_pc;
  logic [2:0]    r_u;
  logic [3:0]    r_sym;
  logic [2:0]    r_cnt;
  logic [2:0]    r_letter;
  logic          r_valid;
  logic          r_error;

  logic          w_tick;
  logic [2:0]    w_u_inc;
  logic          w_dash;
  logic          w_hit;
  logic [2:0]    w_code;

  assign w_tick  = (r_pc == PC_MAX);
  assign w_u_inc = (r_u == 3'd7) ? 3'd7 : r_u + 3'd1;
  assign w_dash  = (r_u >= U_DASH);

  // r_sym bit i holds symbol i (first symbol in bit 0), unused bits are 0
  always_comb begin
    w_hit  = 1'b0;
    w_code = 3'd0;
    case ({r_cnt, r_sym})
      7'b010_0010: begin w_hit = 1'b1; w_code = 3'd0; end
      7'b100_0001: begin w_hit = 1'b1; w_code = 3'd1; end
      7'b100_0101: begin w_hit = 1'b1; w_code = 3'd2; end
      7'b011_0001: begin w_hit = 1'b1; w_code = 3'd3; end
      7'b001_0000: begin w_hit = 1'b1; w_code = 3'd4; end
      7'b100_0100: begin w_hit = 1'b1; w_code = 3'd5; end
      7'b011_0011: begin w_hit = 1'b1; w_code = 3'd6; end
      7'b100_0000: begin w_hit = 1'b1; w_code = 3'd7; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state  <= IDLE;
      r_ks1    <= 1'b0;
      r_ks2    <= 1'b0;
      r_pc     <= '0;
      r_u      <= 3'd0;
      r_sym    <= 4'd0;
      r_cnt    <= 3'd0;
      r_letter <= 3'd0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_ks1   <= key_in;
      r_ks2   <= r_ks1;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_pc    <= w_tick ? '0 : r_pc + 1'b1;
      if (w_tick) r_u <= w_u_inc;
      // key edges are checked before ticks so a coincident tick is dropped
      case (r_state)
        IDLE: begin
          r_pc <= '0;
          r_u  <= 3'd0;
          if (r_ks2) r_state <= MARK;
        end
        MARK: begin
          if (!r_ks2) begin
            r_pc <= '0;
            r_u  <= 3'd0;
            if (r_cnt == 3'd4) begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end else begin
              r_sym[r_cnt[1:0]] <= w_dash;
              r_cnt   <= r_cnt + 3'd1;
              r_state <= SPACE;
            end
          end else if (w_tick && w_u_inc == U_LONG) begin
            r_pc    <= '0;
            r_u     <= 3'd0;
            r_state <= ERROR;
            r_error <= 1'b1;
          end
        end
        SPACE: begin
          if (r_ks2) begin
            r_pc    <= '0;
            r_u     <= 3'd0;
            r_state <= MARK;
          end else if (w_tick && w_u_inc == U_GAP) begin
            r_state <= DECODE;
            if (w_hit) begin
              r_letter <= w_code;
              r_valid  <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        DECODE: begin
          r_state <= IDLE;
          r_cnt   <= 3'd0;
          r_sym   <= 4'd0;
        end
        ERROR: begin
          if (r_ks2) begin
            r_pc <= '0;
            r_u  <= 3'd0;
          end else if (w_tick && w_u_inc == U_GAP) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_sym   <= 4'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign letter    = r_letter;
  assign valid     = r_valid;
  assign error     = r_error;
  assign busy      = (r_state != IDLE);
  assign sym_count = r_cnt;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed cases plus random letters, checked
// by a scoreboard fed from a string-table reference model.
module tb_morse_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;
  logic [2:0] sym_count;

  typedef struct packed {
    logic       is_err;
    logic [2:0] code;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [2:0] last_letter = 3'd0;
  string      tbl[8] = '{".-", "-...", "-.-.", "-..",
                         ".", "..-.", "--.", "...."};

  morse_decoder #(
    .TICK_DIV(4), .DASH_MIN(2), .GAP_UNITS(3), .LONG_MAX(6)
  ) dut (
    .Clock(clk),
    .ResetN(rst_n),
    .key_in(key),
    .letter(letter),
    .valid(valid),
    .error(error),
    .busy(busy),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  function automatic int lookup(string p);
    for (int i = 0; i < 8; i++)
      if (tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic hold(logic v, int n);
    key = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = last_letter;
    q.push_back(e);
  endtask

  task automatic expect_pat(string p);
    int   k;
    exp_t e;
    k = lookup(p);
    if (p.len() > 4 || k < 0) begin
      expect_err();
    end else begin
      e.is_err    = 1'b0;
      e.code      = 3'(k);
      last_letter = 3'(k);
      q.push_back(e);
    end
  endtask

  task automatic send(string p, int gap);
    for (int i = 0; i < p.len(); i++) begin
      if (i > 0) hold(1'b0, int'($urandom_range(2, 10)));
      if (p[i] == 8'h2D) hold(1'b1, int'($urandom_range(10, 24)));
      else hold(1'b1, int'($urandom_range(2, 7)));
    end
    hold(1'b0, gap);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && error) begin
        n_chk++;
        n_fail++;
        $display("FAIL valid_and_error: both high, required exclusive");
      end else if (valid || error) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: valid=%0b error=%0b letter=%0d",
                   valid, error, letter);
        end else begin
          m_e = q.pop_front();
          check("event_kind", {7'd0, error}, {7'd0, m_e.is_err});
          check("event_letter", {5'd0, letter}, {5'd0, m_e.code});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    seen;
    int    r;
    string p;
    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_letter", {5'd0, letter}, 8'd0);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_error", {7'd0, error}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_symcount", {5'd0, sym_count}, 8'd0);
    rst_n = 1'b1;
    hold(1'b0, 4);

    // A with exact latency from final release
    expect_pat(".-");
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 12);
    key  = 1'b0;
    seen = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (valid && seen < 0) seen = i;
    end
    check("A_latency", 8'(seen), 8'd15);
    check("A_letter", {5'd0, letter}, 8'd0);
    check("A_idle", {7'd0, busy}, 8'd0);

    // H, sym_count before and after decode
    expect_pat("....");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) hold(1'b0, 4);
      hold(1'b1, 4);
    end
    hold(1'b0, 6);
    check("H_symcount_pre", {5'd0, sym_count}, 8'd4);
    check("H_busy_pre", {7'd0, busy}, 8'd1);
    hold(1'b0, 14);
    check("H_symcount_post", {5'd0, sym_count}, 8'd0);
    check("H_letter", {5'd0, letter}, 8'd7);

    // unknown pattern "--"
    expect_pat("--");
    hold(1'b1, 12);
    hold(1'b0, 4);
    hold(1'b1, 12);
    hold(1'b0, 20);
    check("unk_letter_hold", {5'd0, letter}, 8'd7);

    // five dots
    expect_pat(".....");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) hold(1'b0, 4);
      hold(1'b1, 4);
    end
    hold(1'b0, 6);
    check("five_busy_err", {7'd0, busy}, 8'd1);
    hold(1'b0, 14);
    check("five_idle", {7'd0, busy}, 8'd0);

    // over-long mark
    expect_err();
    hold(1'b1, 40);
    check("long_busy_held", {7'd0, busy}, 8'd1);
    hold(1'b0, 8);
    check("long_busy_wait", {7'd0, busy}, 8'd1);
    hold(1'b0, 12);
    check("long_idle", {7'd0, busy}, 8'd0);

    // reset mid-letter
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 12);
    hold(1'b0, 6);
    check("mid_symcount", {5'd0, sym_count}, 8'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_letter", {5'd0, letter}, 8'd0);
    check("mid_rst_valid", {7'd0, valid}, 8'd0);
    check("mid_rst_error", {7'd0, error}, 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_symcount", {5'd0, sym_count}, 8'd0);
    last_letter = 3'd0;
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 3);
    expect_pat(".");
    hold(1'b1, 3);
    hold(1'b0, 20);
    check("E_letter", {5'd0, letter}, 8'd4);

    // random letters and random symbol strings
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) begin
        p = tbl[r];
      end else begin
        p = "";
        r = int'($urandom_range(1, 4));
        for (int j = 0; j < r; j++) begin
          if ($urandom_range(0, 1) == 1) p = {p, "-"};
          else p = {p, "."};
        end
      end
      expect_pat(p);
      send(p, int'($urandom_range(16, 26)));
    end

    for (int i = 0; i < 300 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
